prm_edge_scan_ctrl: RTL

- Query-side driver for the obstacle-check logic banks (one combinational checker per roadmap edge, 15-bit voxel code in, one edge_mask bit out).
- Accepts a frame of obstacle voxel codes over a valid/ready stream and presents each code to the checker bank.
- ORs the returned per-edge masks into a sticky "blocked" vector.
- Hands the finished vector to the roadmap planner under a valid/ready handshake.

---
 rtl/prm_scan_pkg.sv | 16 +
 rtl/prm_tag_pipe.sv | 44 ++++
 rtl/prm_edge_scan_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/prm_scan_pkg.sv
// prm_scan_pkg
// Shared definitions for the edge-scan controller: default widths and the
// controller state encoding.
package prm_scan_pkg;

    localparam int CODE_W_DEF = 15;  // voxel code width (checker inputs A..O)
    localparam int N_EDGE_DEF = 64;  // checker instances / roadmap edges

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/prm_tag_pipe.sv
// prm_tag_pipe
// DEPTH-deep 1-bit shift register that travels alongside the checker bank.
// A 1 entering shift_in marks a cycle whose chk_code is a real voxel.
// tag_out says the checker mask currently presented belongs to such a voxel.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   shift_in   : tag entering stage 0
//   tag_out    : last stage
//   any_valid  : OR of all stages (results still in flight)
import prm_scan_pkg::*;

module prm_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_in,
    output logic tag_out,
    output logic any_valid
);

    logic [DEPTH-1:0] stage_reg;
    logic [DEPTH-1:0] stage_next;

    assign stage_next[0] = shift_in;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            assign stage_next[gi] = stage_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign tag_out   = stage_reg[DEPTH-1];
    assign any_valid = |stage_reg;

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// prm_edge_scan_ctrl
// Streams a frame of obstacle voxel codes into the per-edge checker bank.
// It ORs the returned edge masks into a sticky blocked vector.
// It then offers the vector to the planner with a valid/ready handshake.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : begin a new frame (honoured only when idle)
//   vox_valid/code/last/ready: voxel input stream
//   chk_code                 : registered code fanned out to every checker
//   chk_mask                 : per-edge hit bits back from the checker bank
//   blocked, vox_count       : accumulated result and accepted-voxel count
//   result_valid/ready       : result handshake to the planner
//   busy                     : controller is not idle
import prm_scan_pkg::*;

module prm_edge_scan_ctrl #(
    parameter int CODE_W  = CODE_W_DEF,
    parameter int N_EDGE  = N_EDGE_DEF,
    parameter int CHK_LAT = 1,   // checker latency in cycles, must be >= 1
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vox_valid,
    input  logic [CODE_W-1:0] vox_code,
    input  logic              vox_last,
    output logic              vox_ready,
    output logic [CODE_W-1:0] chk_code,
    input  logic [N_EDGE-1:0] chk_mask,
    output logic [N_EDGE-1:0] blocked,
    output logic [CNT_W-1:0]  vox_count,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    scan_state_t       state_reg, state_next;
    logic [CODE_W-1:0] chk_code_reg;
    logic [N_EDGE-1:0] blocked_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              accept;
    logic              tag_out;
    logic              tag_any;

    assign accept = vox_valid && (state_reg == SCAN);

    // Tags follow each accepted code through the checker latency so the mask
    // is only sampled when it belongs to a real voxel.
    prm_tag_pipe #(
        .DEPTH (CHK_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .shift_in  (accept),
        .tag_out   (tag_out),
        .any_valid (tag_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        vox_ready    = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                vox_ready = 1'b1;
                if (accept && vox_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The final mask is folded in on the edge where the last
                // tag leaves, so the pipe reads empty one cycle later.
                if (!tag_any) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_code_reg <= '0;
            blocked_reg  <= '0;
            count_reg    <= '0;
        end else begin
            if (accept) begin
                chk_code_reg <= vox_code;
            end
            if (state_reg == IDLE && start) begin
                blocked_reg <= '0;
                count_reg   <= '0;
            end else begin
                if (tag_out) begin
                    blocked_reg <= blocked_reg | chk_mask;
                end
                if (accept && (count_reg != {CNT_W{1'b1}})) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
        end
    end

    assign chk_code  = chk_code_reg;
    assign blocked   = blocked_reg;
    assign vox_count = count_reg;

endmodule
